// File: rtl/udp_arb_pkg.sv
// udp_arb_pkg: shared constants and register layout for the two-port UDP
// transmit arbiter (udp_tx_arbiter and udp_arb_rr_pick).
package udp_arb_pkg;

  // Arbiter FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Source ports: port 0 is the image sender, port 1 the control/status replier.
  localparam int   NUM_PORTS = 2;
  localparam logic PORT_IMG  = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  // Default timing.
  localparam int DEF_GAP_CYCLES  = 16;
  localparam int DEF_WDOG_CYCLES = 4096;

  // Complete arbiter register state. Held in one struct so the FSM state,
  // round-robin pointer and counters can be probed as a unit.
  typedef struct packed {
    logic [1:0]  state;     // ST_* encoding
    logic        rr;        // port preferred when both request
    logic        grant;     // current / last granted port
    logic [15:0] byte_cnt;  // bytes accepted in DATA
    logic [15:0] len;       // latched payload length of the granted packet
    logic [15:0] gap_cnt;   // cycles spent in GAP
  } arb_regs_t;

endpackage

// File: rtl/udp_arb_rr_pick.sv
// udp_arb_rr_pick: two-requester round-robin selector. A lone requester
// always wins; when both request, the port named by rr wins.
module udp_arb_rr_pick
  import udp_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 rr,
  output logic                 gnt_valid,
  output logic                 gnt_id
);

  // Pick the winner; rr only matters on a tie.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_IMG;
    if (req == 2'b11) begin
      gnt_id = rr;
    end else if (req[1]) begin
      gnt_id = PORT_CTRL;
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP transmit interface between two packet
// sources. Round-robin grant, locked for a whole packet, then GAP_CYCLES of
// idle before the next grant.
//
// Optional build macro UDP_ARB_WATCHDOG_EN: adds a stall watchdog that forces
// GAP (with err_pulse) after WDOG_CYCLES cycles without ack in REQ or without
// a valid byte in DATA. Without it a stalled source holds the grant forever.
//
// Handshake semantics, both sides:
//   - A source raises pN_data_request (with a nonzero, stable pN_data_length)
//     only while pN_tx_ready is high, and holds it until pN_tx_ack. Losing a
//     tie just means the request is held until the port wins.
//   - app_tx_data_request mirrors the granted source's request combinationally
//     in REQ; app_tx_ack in REQ is the only way into DATA.
//   - In DATA a byte transfers on every cycle the granted pN_data_valid is
//     high; there is no backpressure. The byte that reaches the latched
//     length ends the packet.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        p0_tx_ready,
  input  logic        p0_data_request,
  output logic        p0_tx_ack,
  input  logic        p0_data_valid,
  input  logic [7:0]  p0_data,
  input  logic [15:0] p0_data_length,
  output logic        p1_tx_ready,
  input  logic        p1_data_request,
  output logic        p1_tx_ack,
  input  logic        p1_data_valid,
  input  logic [7:0]  p1_data,
  input  logic [15:0] p1_data_length,
  output logic        grant_id,
  output logic        busy,
  output logic        pkt_done,
  output logic        err_pulse
);

  // Last GAP cycle index; 0 and 1 both give a single GAP cycle.
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES <= 1) ? 16'd0 : 16'(GAP_CYCLES - 1);

  arb_regs_t q, d;
  logic [NUM_PORTS-1:0] req_prev_q;
  logic                 pkt_done_d;
  logic                 err_d;

  logic [NUM_PORTS-1:0] req_v;
  logic [NUM_PORTS-1:0] len_ok;
  logic [NUM_PORTS-1:0] req_ok;
  logic [NUM_PORTS-1:0] zero_err;
  logic [NUM_PORTS-1:0] valid_v;
  logic [NUM_PORTS-1:0] owns_data;
  logic [NUM_PORTS-1:0] stray;

  logic        pick_valid;
  logic        pick_id;
  logic        in_idle, in_req, in_data;
  logic        g_req, g_valid;
  logic [7:0]  g_data;
  logic [15:0] cnt_inc;
  logic        wdog_fire;

  assign in_idle = (q.state == ST_IDLE);
  assign in_req  = (q.state == ST_REQ);
  assign in_data = (q.state == ST_DATA);

  // Granted source's signals.
  assign g_req   = q.grant ? p1_data_request : p0_data_request;
  assign g_valid = q.grant ? p1_data_valid   : p0_data_valid;
  assign g_data  = q.grant ? p1_data         : p0_data;

  // A request only counts toward arbitration with a nonzero length.
  assign req_v  = {p1_data_request, p0_data_request};
  assign len_ok = {(p1_data_length != 16'd0), (p0_data_length != 16'd0)};
  assign req_ok = req_v & len_ok;

  // Zero-length request: flagged once, on the rising edge of the request.
  assign zero_err = req_v & ~req_prev_q & ~len_ok;

  // Any valid from a port that does not currently own DATA is dropped and
  // flagged; this covers the losing port and overrun bytes landing in GAP.
  assign valid_v   = {p1_data_valid, p0_data_valid};
  assign owns_data = {in_data & q.grant, in_data & ~q.grant};
  assign stray     = valid_v & ~owns_data;

  assign cnt_inc = q.byte_cnt + 16'd1;

  udp_arb_rr_pick u_pick (
    .req       (req_ok),
    .rr        (q.rr),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

`ifdef UDP_ARB_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_q;
  logic              wdog_stall;

  // Stalled means waiting on the core's ack or on the source's next byte.
  assign wdog_stall = (in_req & ~app_tx_ack) | (in_data & ~g_valid);
  assign wdog_fire  = wdog_stall && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  // Stall counter: clears on any progress and after it fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (wdog_stall && !wdog_fire) begin
      wdog_q <= wdog_q + WDOG_W'(1);
    end else begin
      wdog_q <= '0;
    end
  end
`else
  // No watchdog: the limit is accepted so builds share one parameter list.
  localparam int WDOG_UNUSED = WDOG_CYCLES;
  assign wdog_fire = 1'b0;
`endif

  // Next-state logic for the arbiter FSM and its counters.
  always_comb begin
    d          = q;
    pkt_done_d = 1'b0;
    err_d      = (|zero_err) | (|stray);
    case (q.state)
      ST_IDLE: begin
        if (udp_tx_ready && pick_valid) begin
          d.state = ST_REQ;
          d.grant = pick_id;
          d.len   = pick_id ? p1_data_length : p0_data_length;
        end
      end
      ST_REQ: begin
        if (app_tx_ack) begin
          d.state    = ST_DATA;
          d.byte_cnt = 16'd0;
        end else if (!g_req || wdog_fire) begin
          // Source abandoned the request (or stalled): give up the slot.
          d.state   = ST_GAP;
          d.gap_cnt = 16'd0;
          d.rr      = ~q.grant;
          err_d     = 1'b1;
        end
      end
      ST_DATA: begin
        if (g_valid) begin
          d.byte_cnt = cnt_inc;
          if (cnt_inc == q.len) begin
            d.state    = ST_GAP;
            d.gap_cnt  = 16'd0;
            d.rr       = ~q.grant;
            pkt_done_d = 1'b1;
          end
        end else if (wdog_fire) begin
          d.state   = ST_GAP;
          d.gap_cnt = 16'd0;
          d.rr      = ~q.grant;
          err_d     = 1'b1;
        end
      end
      ST_GAP: begin
        if (q.gap_cnt == GAP_LAST) begin
          d.state = ST_IDLE;
        end else begin
          d.gap_cnt = q.gap_cnt + 16'd1;
        end
      end
      default: begin
        d.state = ST_IDLE;
      end
    endcase
  end

  // State register plus registered pulses and request-edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      req_prev_q <= '0;
      pkt_done   <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      q          <= d;
      req_prev_q <= req_v;
      pkt_done   <= pkt_done_d;
      err_pulse  <= err_d;
    end
  end

  // Ready is gated by reset so every output is low while rst_n is asserted.
  assign p0_tx_ready = rst_n & udp_tx_ready & in_idle;
  assign p1_tx_ready = rst_n & udp_tx_ready & in_idle;

  // Request and ack pass straight through for the granted port only.
  assign app_tx_data_request = in_req & g_req;
  assign p0_tx_ack           = in_req & ~q.grant & app_tx_ack;
  assign p1_tx_ack           = in_req &  q.grant & app_tx_ack;

  // Zero-latency byte path; data is forced to 0 when no byte is offered.
  assign app_tx_data_valid = in_data & g_valid;
  assign app_tx_data       = app_tx_data_valid ? g_data : 8'h00;

  assign udp_data_length = q.len;
  assign grant_id        = q.grant;
  assign busy            = ~in_idle;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed bench for udp_tx_arbiter (GAP_CYCLES=16,
// WDOG_CYCLES=64). The watchdog scenario is only run when
// UDP_ARB_WATCHDOG_EN is defined for the build.
module tb_udp_tx_arbiter;

  localparam int LIMIT = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        udp_tx_ready, app_tx_ack;
  logic        app_tx_data_request, app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;
  logic        p0_tx_ready, p0_data_request, p0_tx_ack, p0_data_valid;
  logic [7:0]  p0_data;
  logic [15:0] p0_data_length;
  logic        p1_tx_ready, p1_data_request, p1_tx_ack, p1_data_valid;
  logic [7:0]  p1_data;
  logic [15:0] p1_data_length;
  logic        grant_id, busy, pkt_done, err_pulse;

  udp_tx_arbiter #(.GAP_CYCLES(16), .WDOG_CYCLES(64)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .udp_data_length     (udp_data_length),
    .p0_tx_ready         (p0_tx_ready),
    .p0_data_request     (p0_data_request),
    .p0_tx_ack           (p0_tx_ack),
    .p0_data_valid       (p0_data_valid),
    .p0_data             (p0_data),
    .p0_data_length      (p0_data_length),
    .p1_tx_ready         (p1_tx_ready),
    .p1_data_request     (p1_data_request),
    .p1_tx_ack           (p1_tx_ack),
    .p1_data_valid       (p1_data_valid),
    .p1_data             (p1_data),
    .p1_data_length      (p1_data_length),
    .grant_id            (grant_id),
    .busy                (busy),
    .pkt_done            (pkt_done),
    .err_pulse           (err_pulse)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int req_cyc  = 0;

  // Monitor on the falling edge: records every byte the core would accept.
  always @(negedge clk) begin
    if (app_tx_data_valid) got_q.push_back(app_tx_data);
    if (pkt_done) done_cnt++;
    if (err_pulse) err_cnt++;
    if (app_tx_data_request) req_cyc++;
  end

  // Absolute time guard.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic port, input int i);
    return 8'(i * 7 + (port ? 90 : 3));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic val, input logic [15:0] len);
    if (port) begin
      p1_data_request = val;
      p1_data_length  = len;
    end else begin
      p0_data_request = val;
      p0_data_length  = len;
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!app_tx_data_request && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!p0_tx_ready && n < LIMIT) begin
      step();
      n++;
    end
  endtask

  // Withholds ack for 'delay' REQ cycles, then acks once and drops the request.
  task automatic ack_phase(input logic port, input int delay, input logic [15:0] len,
                           input string tag);
    for (int i = 0; i < delay; i++) step();
    check({tag, " core req"}, 32'(app_tx_data_request), 32'd1);
    check({tag, " length"}, 32'(udp_data_length), 32'(len));
    app_tx_ack = 1'b1;
    #1;
    check({tag, " ack own"}, 32'(port ? p1_tx_ack : p0_tx_ack), 32'd1);
    check({tag, " ack other"}, 32'(port ? p0_tx_ack : p1_tx_ack), 32'd0);
    step();
    app_tx_ack = 1'b0;
    set_req(port, 1'b0, len);
  endtask

  // Drives 'beats' contiguous bytes; only the first 'len' are expected.
  // With intrude set, port 1 drives junk valid beats 10..14.
  task automatic send_bytes(input logic port, input int beats, input int len, input bit intrude);
    for (int i = 0; i < beats; i++) begin
      if (port) begin
        p1_data_valid = 1'b1;
        p1_data       = pat(1'b1, i);
      end else begin
        p0_data_valid = 1'b1;
        p0_data       = pat(1'b0, i);
      end
      if (i < len) exp_q.push_back(pat(port, i));
      if (intrude) begin
        p1_data_valid = (i >= 10 && i < 15);
        p1_data       = (i >= 10 && i < 15) ? 8'hEE : 8'h00;
      end
      step();
    end
    p0_data_valid = 1'b0;
    p1_data_valid = 1'b0;
    p0_data       = 8'h00;
    p1_data       = 8'h00;
  endtask

  task automatic check_pkt(input string tag, input int gbase);
    int got_n;
    int bad;
    got_n = got_q.size() - gbase;
    bad   = 0;
    check({tag, " byte count"}, 32'(got_n), 32'(exp_q.size()));
    for (int k = 0; k < got_n && k < exp_q.size(); k++)
      if (got_q[gbase + k] !== exp_q[k]) bad++;
    check({tag, " byte mism"}, 32'(bad), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Full packet: request, arbitration check, ack, bytes, scoreboard.
  task automatic full_pkt(input logic port, input logic [15:0] len, input int delay,
                          input string tag);
    int n;
    int gb;
    exp_q.delete();
    gb = got_q.size();
    set_req(port, 1'b1, len);
    wait_req(n);
    check({tag, " grant wait"}, 32'(n < LIMIT), 32'd1);
    check({tag, " grant id"}, 32'(grant_id), 32'(port));
    ack_phase(port, delay, len, tag);
    send_bytes(port, len, len, 1'b0);
    check_pkt(tag, gb);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, e0, d0, r0, gb;
    udp_tx_ready = 1'b1;
    app_tx_ack = 1'b0;
    p0_data_request = 1'b0; p0_data_valid = 1'b0; p0_data = 8'h00; p0_data_length = 16'd0;
    p1_data_request = 1'b0; p1_data_valid = 1'b0; p1_data = 8'h00; p1_data_length = 16'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state: everything low, even with the core ready.
    check("reset ctl", {26'd0, p0_tx_ready, p1_tx_ready, app_tx_data_request,
                        app_tx_data_valid, p0_tx_ack, p1_tx_ack}, 32'd0);
    check("reset misc", {28'd0, grant_id, busy, pkt_done, err_pulse}, 32'd0);
    check("reset data", {8'd0, app_tx_data, udp_data_length}, 32'd0);
    rst_n = 1'b1;
    step();
    check("idle ready", 32'({p1_tx_ready, p0_tx_ready}), 32'd3);

    // T1: port 0 alone, 668 bytes, ack 3 cycles late, 16-cycle gap.
    e0 = err_cnt; d0 = done_cnt;
    full_pkt(1'b0, 16'd668, 3, "t1");
    wait_idle(n);
    check("t1 gap cycles", 32'(n), 32'd16);
    check("t1 pkt_done", 32'(done_cnt - d0), 32'd1);
    check("t1 no err", 32'(err_cnt - e0), 32'd0);

    // T2: simultaneous requests after reset: p0 first, then p1 beats a
    // re-requesting p0, then p0 again.
    do_reset();
    set_req(1'b1, 1'b1, 16'd40);
    full_pkt(1'b0, 16'd668, 0, "t2 p0 first");
    set_req(1'b0, 1'b1, 16'd668);
    full_pkt(1'b1, 16'd40, 0, "t2 p1 second");
    full_pkt(1'b0, 16'd668, 0, "t2 p0 third");
    wait_idle(n);

    // T3: port 1 drives junk valid while port 0 owns DATA.
    e0 = err_cnt; d0 = done_cnt;
    exp_q.delete();
    gb = got_q.size();
    set_req(1'b0, 1'b1, 16'd64);
    wait_req(n);
    check("t3 grant id", 32'(grant_id), 32'd0);
    ack_phase(1'b0, 1, 16'd64, "t3");
    send_bytes(1'b0, 64, 64, 1'b1);
    check_pkt("t3 p0 intact", gb);
    check("t3 stray err", 32'(err_cnt - e0), 32'd5);
    wait_idle(n);
    check("t3 pkt_done", 32'(done_cnt - d0), 32'd1);

    // T4a: zero-length request is never granted and flags once.
    e0 = err_cnt; r0 = req_cyc;
    set_req(1'b0, 1'b1, 16'd0);
    repeat (8) step();
    check("t4a busy", 32'(busy), 32'd0);
    check("t4a err once", 32'(err_cnt - e0), 32'd1);
    check("t4a no core req", 32'(req_cyc - r0), 32'd0);
    set_req(1'b0, 1'b0, 16'd0);
    step();

    // T4b: port 1 drops its request in REQ before any ack.
    e0 = err_cnt;
    gb = got_q.size();
    set_req(1'b1, 1'b1, 16'd40);
    wait_req(n);
    check("t4b grant id", 32'(grant_id), 32'd1);
    step();
    set_req(1'b1, 1'b0, 16'd40);
    step();
    check("t4b in gap", 32'({busy, p1_tx_ready, app_tx_data_request}), 32'b100);
    step();
    check("t4b err", 32'(err_cnt - e0), 32'd1);
    wait_idle(n);
    check("t4b back idle", 32'(n < LIMIT), 32'd1);
    check("t4b no bytes", 32'(got_q.size() - gb), 32'd0);

    // T4c: port 1 sends two bytes past its length; both dropped and flagged.
    e0 = err_cnt; d0 = done_cnt;
    exp_q.delete();
    gb = got_q.size();
    set_req(1'b1, 1'b1, 16'd40);
    wait_req(n);
    check("t4c grant id", 32'(grant_id), 32'd1);
    ack_phase(1'b1, 0, 16'd40, "t4c");
    send_bytes(1'b1, 42, 40, 1'b0);
    wait_idle(n);
    check_pkt("t4c overrun", gb);
    check("t4c err", 32'(err_cnt - e0), 32'd2);
    check("t4c pkt_done", 32'(done_cnt - d0), 32'd1);

    // T5: reset at byte 300 of 668, then a clean packet.
    exp_q.delete();
    set_req(1'b0, 1'b1, 16'd668);
    wait_req(n);
    ack_phase(1'b0, 0, 16'd668, "t5 pre");
    send_bytes(1'b0, 300, 300, 1'b0);
    p0_data_valid = 1'b1;
    p0_data = pat(1'b0, 300);
    rst_n = 1'b0;
    #1;
    check("t5 rst ctl", {27'd0, p0_tx_ready, app_tx_data_request, app_tx_data_valid,
                         grant_id, busy}, 32'd0);
    check("t5 rst data", {8'd0, app_tx_data, udp_data_length}, 32'd0);
    p0_data_valid = 1'b0;
    p0_data = 8'h00;
    step();
    rst_n = 1'b1;
    step();
    d0 = done_cnt; e0 = err_cnt;
    full_pkt(1'b0, 16'd668, 2, "t5 post");
    wait_idle(n);
    check("t5 pkt_done", 32'(done_cnt - d0), 32'd1);
    check("t5 no err", 32'(err_cnt - e0), 32'd0);

`ifdef UDP_ARB_WATCHDOG_EN
    // T6: port 0 stalls after byte 100; watchdog frees the interface.
    exp_q.delete();
    set_req(1'b0, 1'b1, 16'd668);
    wait_req(n);
    ack_phase(1'b0, 0, 16'd668, "t6 p0");
    send_bytes(1'b0, 100, 100, 1'b0);
    set_req(1'b1, 1'b1, 16'd40);
    e0 = err_cnt;
    n = 0;
    while (!err_pulse && n < 200) begin
      step();
      n++;
    end
    check("t6 wdog cycles", 32'(n), 32'd64);
    check("t6 in gap", 32'({busy, p0_tx_ready}), 32'b10);
    full_pkt(1'b1, 16'd40, 0, "t6 p1");
    wait_idle(n);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit interface (request/ack, byte stream, length) between two packet sources.
  - Port 0: image sender.
  - Port 1: control/status reply sender.
- Sits between the sources and the UDP stack; each source sees an interface identical to a private UDP core.
- Round-robin grant, locked for a whole packet, followed by a programmable inter-packet gap.

Parameters:
- GAP_CYCLES, 16: idle cycles after each packet before the next grant.
- WDOG_CYCLES, 4096: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- udp_tx_ready  in  1  UDP core ready.
- app_tx_ack  in  1  UDP core accepts request.
- app_tx_data_request  out  1  request to core.
- app_tx_data_valid  out  1  byte valid to core.
- app_tx_data  out  8  byte to core.
- udp_data_length  out  16  payload length to core.
- pN_tx_ready  out  1  (N=0,1) per-port ready.
- pN_data_request  in  1  per-port request.
- pN_tx_ack  out  1  per-port ack.
- pN_data_valid  in  1  per-port byte valid.
- pN_data  in  8  per-port byte.
- pN_data_length  in  16  per-port payload length; must be stable from request until ack.
- grant_id  out  1  current/last granted port.
- busy  out  1  state is not IDLE.
- pkt_done  out  1  one-cycle pulse at packet end.
- err_pulse  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; round-robin pointer rr=0 (port 0 preferred first); byte counter 0; latched length 0.
- States: IDLE, REQ, DATA, GAP.
- pN_tx_ready = udp_tx_ready & (state==IDLE). Both ports may see ready together; a losing port holds its request.
- IDLE:
  - Evaluate pN_data_request with nonzero pN_data_length.
  - One requester: grant it. Both: grant port rr.
  - On grant: latch grant_id; latch length into udp_data_length (registered); go to REQ.
  - A request with pN_data_length==0 is never granted and pulses err_pulse once per rising edge of that request.
- REQ:
  - app_tx_data_request = p[grant]_data_request (combinational, so the core never sees a stale request after the source drops it).
  - p[grant]_tx_ack = app_tx_ack (combinational); the other port's ack is 0.
  - app_tx_ack → DATA, counter cleared.
  - If the granted source deasserts request before ack: go to GAP, rr flips, err_pulse.
- DATA:
  - app_tx_data_valid/app_tx_data = granted port's valid/data, combinational, zero latency.
  - Counter +1 on each valid byte.
  - The byte that brings the counter to the latched length → GAP, pkt_done pulses next cycle, rr = ~grant_id.
  - Counter width 16; no wrap possible because exit occurs at equality.
- GAP:
  - Counts GAP_CYCLES, then IDLE. All ready/request outputs 0.
  - GAP_CYCLES=0 means a one-cycle pass through GAP.
- Non-granted port:
  - Valid is ignored and never reaches the core.
  - Valid asserted while that port is not in DATA pulses err_pulse.
- Bytes beyond the length: the extra valid beats in GAP are dropped with err_pulse.
- Simultaneous events: pkt_done and err_pulse may coincide.
- Mid-operation reset: immediate return to reset values; no partial-packet recovery.

Optional Feature:
- Macro UDP_ARB_WATCHDOG_EN.
- With the macro defined:
  - A cycle counter runs in REQ (no ack yet) and in DATA (no valid byte on the current cycle); it clears on every ack or valid byte.
  - Reaching WDOG_CYCLES forces GAP, flips rr, and pulses err_pulse.
- Without the macro:
  - No watchdog logic; a stalled source holds the grant indefinitely.

Decomposition:
- Shared package udp_arb_pkg holds:
  - state encodings IDLE=0, REQ=1, DATA=2, GAP=3;
  - port count 2 and port ID constants;
  - default GAP_CYCLES and WDOG_CYCLES.
- One natural sub-module: udp_arb_rr_pick, a two-requester round-robin selector taking the valid requests and rr and returning a grant and grant ID.

Test Plan:
- Port 0 alone:
  - Stimulus: length 668, request held until ack (ack 3 cycles after request), 668 contiguous bytes.
  - Required response: core sees request, length 668 and all bytes in order; pkt_done once; GAP lasts 16 cycles before pN_tx_ready returns.
- Both ports request in the same cycle after reset (p0 len 668, p1 len 40):
  - Required response: port 0 served first, then port 1.
  - Repeat the simultaneous request: port 1 served first this time.
- Port 1 drives valid while port 0 owns DATA:
  - Required response: port 1 bytes never reach app_tx_data; err_pulse asserted; port 0 packet unaffected.
- Zero length and early drop:
  - Port 0 requests with length 0 → no grant, one err_pulse.
  - Port 1 drops its request in REQ before ack → GAP, err_pulse.
- Reset asserted mid-DATA (byte 300 of 668):
  - Required response: all outputs 0 asynchronously; after release, a fresh port-0 packet completes normally.
- With UDP_ARB_WATCHDOG_EN, WDOG_CYCLES=64:
  - Stimulus: port 0 stops valid at byte 100.
  - Required response: after 64 idle cycles, state goes to GAP, err_pulse asserted, and port 1 is then grantable.
